io_output_bank: RTL and testbench
=================================

IO_OUTPUT_BANK -- requirements
Module: io_output_bank

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, number of independent output pad channels (legal range 1..32).
REQ-002 The module SHALL have parameter CFG_W, default 2*NUM_CH, length of the configuration chain; it SHALL NOT be overridden.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port config_enable, input, 1 bit: when high, the configuration chain shifts by one bit per cycle.
REQ-006 The module SHALL have port ccff_head, input, 1 bit: serial configuration data in.
REQ-007 The module SHALL have port ccff_tail, output, 1 bit: serial configuration data out, used for daisy-chaining.
REQ-008 The module SHALL have port io_output_outpad, input, NUM_CH bits: fabric data, one bit per channel.
REQ-009 The module SHALL have port gfpga_pad_GPOUT_PAD_out, output, NUM_CH bits: pad drive value.
REQ-010 The module SHALL have port gfpga_pad_GPOUT_PAD_oe, output, NUM_CH bits: pad output enable, active-high.

Function
REQ-011 The configuration register cfg[CFG_W-1:0] SHALL shift when config_enable=1: cfg <= {cfg[CFG_W-2:0], ccff_head}.
REQ-012 ccff_tail SHALL equal cfg[CFG_W-1] combinationally.
REQ-013 Channel k mode SHALL be cfg[2k+1:2k]: 00=OFF, 01=BYPASS, 10=REG, 11=TOGGLE.
REQ-014 In OFF mode, oe[k]=0 and out[k]=0.
REQ-015 In BYPASS mode, oe[k]=1 and out[k]=io_output_outpad[k] combinationally, with zero latency.
REQ-016 In REG mode, oe[k]=1 and out[k]=q[k], where q[k] <= io_output_outpad[k] every cycle; latency is 1 cycle.
REQ-017 In TOGGLE mode, oe[k]=1 and out[k]=q[k], where q[k] <= ~q[k] on each cycle with io_output_outpad[k]=1 and prev[k]=0; prev[k] <= io_output_outpad[k] every cycle.
REQ-018 A TOGGLE edge SHALL produce exactly one inversion of q[k], visible 1 cycle after the first cycle outpad is sampled high; held-high input SHALL NOT toggle again.
REQ-019 While config_enable=1, all oe SHALL be 0 and all out SHALL be 0, and q and prev SHALL be cleared to 0 each cycle.
REQ-020 A new mode SHALL take effect in the first cycle after config_enable falls; REG and TOGGLE start from q=0 and prev=0.
REQ-021 q and prev SHALL update in every mode, but out and oe SHALL follow only the current mode's selection.
REQ-022 Channels SHALL be fully independent; one channel's mode or data SHALL NOT affect another.
REQ-023 The outputs SHALL NOT glitch on mode change other than via the registered cfg, so cfg SHALL be the only mode source.

Reset
REQ-024 On clk rising with reset=1, cfg, q and prev SHALL clear to 0, giving all channels OFF, oe=0, out=0 and ccff_tail=0.
REQ-025 reset SHALL take priority over config_enable; a chain load interrupted by reset SHALL be discarded entirely.
REQ-026 No asynchronous reset path SHALL exist.

Structure
REQ-027 Mode encodings (OFF/BYPASS/REG/TOGGLE) SHALL be a 2-bit enum typedef in shared package io_tile_pkg, together with a function returning CFG_W for a given NUM_CH.
REQ-028 Per-channel datapath (q, prev and the output mux) SHALL be a sub-module io_output_chan instantiated NUM_CH times by a generate loop.
REQ-029 The config chain SHALL remain in io_output_bank so that a single shift register spans all channels.

Verification
REQ-030 Reset check: reset=1 for 2 cycles, then release with config_enable=0 -> oe=0000, out=0000 and ccff_tail=0 for NUM_CH=4.
REQ-031 Chain load: shift 8 bits 1,1,1,0,0,1,0,0 with config_enable=1 -> cfg=8'b11100100, giving ch0=OFF, ch1=BYPASS, ch2=REG, ch3=TOGGLE; oe=0000 during the shift and oe=1110 after.
REQ-032 Latency check: with the above config, drive outpad=1111 for 1 cycle -> out[1]=1 in the same cycle, out[2]=1 one cycle later, out[3] inverts once, and out[0]=0.
REQ-033 Toggle check: in TOGGLE mode, outpad[3] sequence 0,1,1,0,1 -> out[3] sequence 0,0,1,1,1,0 (shifted by 1 cycle), giving two inversions only.
REQ-034 Daisy-chain and interrupt check: a further 8 shifts of 0 -> ccff_tail replays 1,1,1,0,0,1,0,0; assert reset mid-shift after 3 bits -> cfg=0 and all OFF.

Source files
------------

// File: rtl/io_tile_pkg.sv
// Shared definitions for the IO tile: pad channel mode encodings and
// configuration chain sizing.
package io_tile_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_BYPASS = 2'b01,
    MODE_REG    = 2'b10,
    MODE_TOGGLE = 2'b11
  } io_mode_e;

  localparam int MODE_W = 2;

  function automatic int cfg_width(input int num_ch);
    return MODE_W * num_ch;
  endfunction

endpackage

// File: rtl/io_output_chan.sv
// One output pad channel: the q/prev state registers and the mode-selected
// drive/enable mux.
module io_output_chan
  import io_tile_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     cfg_active,
  input  io_mode_e mode,
  input  logic     outpad,
  output logic     pad_out,
  output logic     pad_oe
);

  logic q_r;
  logic prev_r;
  logic q_next_s;

  // Next value of q; only TOGGLE holds q between rising input edges
  always_comb begin
    q_next_s = outpad;
    case (mode)
      MODE_TOGGLE: begin
        if (outpad && !prev_r) begin
          q_next_s = ~q_r;
        end else begin
          q_next_s = q_r;
        end
      end
      default: begin
        q_next_s = outpad;
      end
    endcase
  end

  // State registers, held clear while the chain is being loaded
  always_ff @(posedge clk) begin
    if (reset || cfg_active) begin
      q_r    <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      prev_r <= outpad;
    end
  end

  // Pad drive mux; everything is released while configuration shifts
  always_comb begin
    pad_out = 1'b0;
    pad_oe  = 1'b0;
    if (cfg_active) begin
      pad_out = 1'b0;
      pad_oe  = 1'b0;
    end else begin
      case (mode)
        MODE_OFF: begin
          pad_out = 1'b0;
          pad_oe  = 1'b0;
        end
        MODE_BYPASS: begin
          pad_out = outpad;
          pad_oe  = 1'b1;
        end
        MODE_REG, MODE_TOGGLE: begin
          pad_out = q_r;
          pad_oe  = 1'b1;
        end
        default: begin
          pad_out = 1'b0;
          pad_oe  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/io_output_bank.sv
// Bank of NUM_CH output pad channels configured through one serial
// shift chain spanning every channel.
module io_output_bank
  import io_tile_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CFG_W  = cfg_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              config_enable,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic [NUM_CH-1:0] io_output_outpad,
  output logic [NUM_CH-1:0] gfpga_pad_GPOUT_PAD_out,
  output logic [NUM_CH-1:0] gfpga_pad_GPOUT_PAD_oe
);

  logic [CFG_W-1:0] cfg_r;

  // Configuration chain; reset wins over a shift in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_r <= {CFG_W{1'b0}};
    end else if (config_enable) begin
      cfg_r <= {cfg_r[CFG_W-2:0], ccff_head};
    end else begin
      cfg_r <= cfg_r;
    end
  end

  assign ccff_tail = cfg_r[CFG_W-1];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    io_output_chan u_chan (
      .clk        (clk),
      .reset      (reset),
      .cfg_active (config_enable),
      .mode       (io_mode_e'(cfg_r[MODE_W*k +: MODE_W])),
      .outpad     (io_output_outpad[k]),
      .pad_out    (gfpga_pad_GPOUT_PAD_out[k]),
      .pad_oe     (gfpga_pad_GPOUT_PAD_oe[k])
    );
  end

endmodule

// File: tb/tb_io_output_bank.sv
// Directed self-checking bench for io_output_bank with NUM_CH=4.
module tb_io_output_bank;

  logic       clk;
  logic       reset;
  logic       config_enable;
  logic       ccff_head;
  logic       ccff_tail;
  logic [3:0] io_output_outpad;
  logic [3:0] pad_out;
  logic [3:0] pad_oe;

  int checks;
  int failures;

  logic [7:0] pattern;

  io_output_bank #(.NUM_CH(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .config_enable           (config_enable),
    .ccff_head               (ccff_head),
    .ccff_tail               (ccff_tail),
    .io_output_outpad        (io_output_outpad),
    .gfpga_pad_GPOUT_PAD_out (pad_out),
    .gfpga_pad_GPOUT_PAD_oe  (pad_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift the 8-bit pattern MSB first; outputs must stay released throughout
  task automatic load_chain();
    for (int i = 0; i < 8; i++) begin
      config_enable = 1'b1;
      ccff_head     = pattern[7-i];
      #1;
      checks++;
      if (pad_oe !== 4'b0000 || pad_out !== 4'b0000) begin
        $display("FAIL load_shift bit %0d: oe=%b out=%b expected oe=0000 out=0000", i, pad_oe, pad_out);
        failures++;
      end
      step();
    end
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    config_enable    = 1'b0;
    ccff_head        = 1'b0;
    io_output_outpad = 4'b1111;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (pad_oe !== 4'b0000 || pad_out !== 4'b0000 || ccff_tail !== 1'b0) begin
      $display("FAIL reset: oe=%b out=%b tail=%b expected 0000 0000 0", pad_oe, pad_out, ccff_tail);
      failures++;
    end
  endtask

  task automatic test_chain_load();
    io_output_outpad = 4'b1111;
    load_chain();
    io_output_outpad = 4'b0000;
    #1;
    checks++;
    if (pad_oe !== 4'b1110 || pad_out !== 4'b0000) begin
      $display("FAIL chain_load: oe=%b out=%b expected oe=1110 out=0000", pad_oe, pad_out);
      failures++;
    end
    checks++;
    if (ccff_tail !== 1'b1) begin
      $display("FAIL chain_tail: tail=%b expected 1", ccff_tail);
      failures++;
    end
  endtask

  task automatic test_latency();
    logic [3:0] exp_out [3];
    exp_out[0] = 4'b0010;
    exp_out[1] = 4'b1100;
    exp_out[2] = 4'b1000;
    io_output_outpad = 4'b1111;
    #1;
    checks++;
    if (pad_out !== exp_out[0]) begin
      $display("FAIL latency_same_cycle: out=%b expected %b", pad_out, exp_out[0]);
      failures++;
    end
    step();
    io_output_outpad = 4'b0000;
    #1;
    checks++;
    if (pad_out !== exp_out[1]) begin
      $display("FAIL latency_next_cycle: out=%b expected %b", pad_out, exp_out[1]);
      failures++;
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (pad_out !== exp_out[2] || pad_oe !== 4'b1110) begin
        $display("FAIL latency_settled %0d: out=%b oe=%b expected out=%b oe=1110", i, pad_out, pad_oe, exp_out[2]);
        failures++;
      end
    end
  endtask

  task automatic test_toggle();
    logic [4:0] stim;
    logic [4:0] exp_q;
    stim  = 5'b10110;
    exp_q = 5'b01110;
    load_chain();
    io_output_outpad = 4'b0000;
    #1;
    checks++;
    if (pad_out[3] !== 1'b0) begin
      $display("FAIL toggle_start: out3=%b expected 0", pad_out[3]);
      failures++;
    end
    for (int i = 0; i < 5; i++) begin
      io_output_outpad = {stim[i], 3'b000};
      step();
      checks++;
      if (pad_out[3] !== exp_q[i]) begin
        $display("FAIL toggle_seq %0d: out3=%b expected %b", i, pad_out[3], exp_q[i]);
        failures++;
      end
    end
    io_output_outpad = 4'b0000;
    #1;
  endtask

  task automatic test_daisy_chain();
    for (int i = 0; i < 8; i++) begin
      config_enable = 1'b1;
      ccff_head     = 1'b0;
      #1;
      checks++;
      if (ccff_tail !== pattern[7-i]) begin
        $display("FAIL daisy_tail %0d: tail=%b expected %b", i, ccff_tail, pattern[7-i]);
        failures++;
      end
      step();
    end
    config_enable = 1'b0;
    io_output_outpad = 4'b1111;
    #1;
    checks++;
    if (pad_oe !== 4'b0000 || ccff_tail !== 1'b0) begin
      $display("FAIL daisy_flushed: oe=%b tail=%b expected 0000 0", pad_oe, ccff_tail);
      failures++;
    end
  endtask

  task automatic test_reset_interrupt();
    io_output_outpad = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      config_enable = 1'b1;
      ccff_head     = pattern[7-i];
      step();
    end
    reset = 1'b1;
    step();
    reset         = 1'b0;
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    #1;
    checks++;
    if (pad_oe !== 4'b0000 || pad_out !== 4'b0000 || ccff_tail !== 1'b0) begin
      $display("FAIL reset_interrupt: oe=%b out=%b tail=%b expected 0000 0000 0", pad_oe, pad_out, ccff_tail);
      failures++;
    end
    step();
    checks++;
    if (pad_oe !== 4'b0000 || pad_out !== 4'b0000) begin
      $display("FAIL reset_interrupt_hold: oe=%b out=%b expected 0000 0000", pad_oe, pad_out);
      failures++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    pattern  = 8'b11100100;
    test_reset();
    test_chain_load();
    test_latency();
    test_toggle();
    test_daisy_chain();
    test_reset_interrupt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
